// File: rtl/video_frame_timer.sv
// -----------------------------------------------------------------------------
// video_frame_timer
//
// Pixel-rate re-timer and timing monitor for the LSPC sync generator output.
// Every CE_PIX clock the raw sync/blank inputs are registered into a
// pixel-aligned output set that appears one clock later, together with
// CE_PIXEL_O. Alongside, the line length and frame height are measured. A
// SEARCH/MEASURE/LOCKED state machine gates DE, so active video is only
// emitted once the timing has been stable for a full frame. An optional crop
// blanks CROP_PIX pixels at both edges of each active line.
//
// Ports
//   CLK_24MB    in   system clock
//   nRESETP     in   asynchronous active-low reset
//   CE_PIX      in   one-clock pixel strobe (1 in 4 clocks)
//   HSYNC       in   horizontal sync, active low
//   VSYNC       in   vertical sync, active low
//   HBLANK_IN   in   horizontal blank, active high
//   VBLANK_IN   in   vertical blank, active high
//   CROP304     in   1 = blank CROP_PIX pixels at each active-line edge
//   CE_PIXEL_O  out  CE_PIX delayed one clock
//   HS_O        out  registered HSYNC
//   VS_O        out  registered VSYNC
//   HBLANK_O    out  registered horizontal blank, including crop
//   VBLANK_O    out  registered vertical blank
//   DE          out  data enable (LOCKED and not blanked)
//   LOCKED      out  lock state machine is in LOCKED
//   H_TOTAL     out  last measured pixels per line
//   V_TOTAL     out  last measured lines per frame
//   FRAME_CNT   out  number of frames started while locked (wraps)
// -----------------------------------------------------------------------------
module video_frame_timer #(
  parameter int H_MIN    = 380,
  parameter int H_MAX    = 388,
  parameter int V_MIN    = 260,
  parameter int V_MAX    = 316,
  parameter int CROP_PIX = 8,
  parameter int ACT_PIX  = 320
) (
  input  logic       CLK_24MB,
  input  logic       nRESETP,
  input  logic       CE_PIX,
  input  logic       HSYNC,
  input  logic       VSYNC,
  input  logic       HBLANK_IN,
  input  logic       VBLANK_IN,
  input  logic       CROP304,
  output logic       CE_PIXEL_O,
  output logic       HS_O,
  output logic       VS_O,
  output logic       HBLANK_O,
  output logic       VBLANK_O,
  output logic       DE,
  output logic       LOCKED,
  output logic [9:0] H_TOTAL,
  output logic [8:0] V_TOTAL,
  output logic [7:0] FRAME_CNT
);

  localparam logic [9:0] H_MIN_C   = 10'(H_MIN);
  localparam logic [9:0] H_MAX_C   = 10'(H_MAX);
  localparam logic [8:0] V_MIN_C   = 9'(V_MIN);
  localparam logic [8:0] V_MAX_C   = 9'(V_MAX);
  localparam logic [8:0] CROP_LO_C = 9'(CROP_PIX);
  localparam logic [8:0] CROP_HI_C = 9'(ACT_PIX - CROP_PIX);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t     state_q;

  // Input history and measurement state
  logic       hs_hist_p0;
  logic       vs_hist_p0;
  logic       crop_p0;
  logic       bad_seen_q;
  logic [9:0] hcnt_q;
  logic [8:0] vcnt_q;
  logic [8:0] acnt_q;
  logic [9:0] htot_q;
  logic [8:0] vtot_q;
  logic [7:0] fcnt_q;

  // Output register set
  logic       vld_p1;
  logic       hs_p1;
  logic       vs_p1;
  logic       hblank_p1;
  logic       vblank_p1;
  logic       locked_p1;

  // Counters hold at all-ones instead of wrapping, so a missing sync can
  // never alias back into the legal window.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  logic       hfall;
  logic       vfall;
  logic       h_out_rng;
  logic       h_changed;
  logic       bad_line;
  logic       bad_frame;
  logic       v_in_rng;
  logic       v_changed;
  logic       timeout;
  logic       crop_edge;
  logic       hblank_nxt;
  logic [8:0] vcnt_nxt;

  always_comb begin
    hfall     = CE_PIX & ~HSYNC & hs_hist_p0;
    vfall     = CE_PIX & ~VSYNC & vs_hist_p0;
    // hcnt_q holds the length of the line that this hfall terminates
    h_out_rng = (hcnt_q < H_MIN_C) || (hcnt_q > H_MAX_C);
    h_changed = (state_q == ST_LOCKED) && (hcnt_q != htot_q);
    bad_line  = hfall & (h_out_rng | h_changed);
    // a bad line ending exactly on the vfall still belongs to the old frame
    bad_frame = bad_seen_q | bad_line;
    v_in_rng  = (vcnt_q >= V_MIN_C) && (vcnt_q <= V_MAX_C);
    v_changed = (vcnt_q != vtot_q);

    vcnt_nxt = vcnt_q;
    if (vfall) begin
      // a coincident hfall is the first line of the new frame
      vcnt_nxt = hfall ? 9'd1 : 9'd0;
    end else if (hfall) begin
      vcnt_nxt = sat_inc9(vcnt_q);
    end
    timeout = CE_PIX & ~vfall & (vcnt_nxt > V_MAX_C);

    crop_edge  = (acnt_q < CROP_LO_C) || (acnt_q >= CROP_HI_C);
    hblank_nxt = HBLANK_IN | (crop_p0 & crop_edge);
  end

  // Stage p0: edge history, counters and measurements
  always_ff @(posedge CLK_24MB or negedge nRESETP) begin
    if (!nRESETP) begin
      hs_hist_p0 <= 1'b1;
      vs_hist_p0 <= 1'b1;
      crop_p0    <= 1'b0;
      bad_seen_q <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      acnt_q     <= '0;
      htot_q     <= '0;
      vtot_q     <= '0;
      fcnt_q     <= '0;
    end else if (CE_PIX) begin
      hs_hist_p0 <= HSYNC;
      vs_hist_p0 <= VSYNC;
      crop_p0    <= CROP304;

      if (hfall) begin
        htot_q <= hcnt_q;
        hcnt_q <= 10'd1;
      end else begin
        hcnt_q <= sat_inc10(hcnt_q);
      end

      vcnt_q <= vcnt_nxt;
      if (vfall) begin
        vtot_q <= vcnt_q;
      end

      if (vfall) begin
        bad_seen_q <= 1'b0;
      end else if (bad_line) begin
        bad_seen_q <= 1'b1;
      end

      // counted against the state before any transition on this vfall
      if (vfall && (state_q == ST_LOCKED)) begin
        fcnt_q <= fcnt_q + 8'd1;
      end

      if (HBLANK_IN) begin
        acnt_q <= '0;
      end else begin
        acnt_q <= sat_inc9(acnt_q);
      end
    end
  end

  // Lock state machine; LOCKED is registered with the state
  always_ff @(posedge CLK_24MB or negedge nRESETP) begin
    if (!nRESETP) begin
      state_q   <= ST_SEARCH;
      locked_p1 <= 1'b0;
    end else if (CE_PIX) begin
      if (timeout) begin
        state_q   <= ST_SEARCH;
        locked_p1 <= 1'b0;
      end else begin
        case (state_q)
          ST_SEARCH: begin
            if (vfall) begin
              state_q <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (vfall && v_in_rng && !bad_frame) begin
              state_q   <= ST_LOCKED;
              locked_p1 <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (bad_line || (vfall && v_changed)) begin
              state_q   <= ST_MEASURE;
              locked_p1 <= 1'b0;
            end
          end
          default: begin
            state_q   <= ST_SEARCH;
            locked_p1 <= 1'b0;
          end
        endcase
      end
    end
  end

  // Stage p1: pixel-aligned output registers, one clock behind CE_PIX
  always_ff @(posedge CLK_24MB or negedge nRESETP) begin
    if (!nRESETP) begin
      vld_p1    <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
      hblank_p1 <= 1'b1;
      vblank_p1 <= 1'b1;
    end else begin
      vld_p1 <= CE_PIX;
      if (CE_PIX) begin
        hs_p1     <= HSYNC;
        vs_p1     <= VSYNC;
        hblank_p1 <= hblank_nxt;
        vblank_p1 <= VBLANK_IN;
      end
    end
  end

  assign CE_PIXEL_O = vld_p1;
  assign HS_O       = hs_p1;
  assign VS_O       = vs_p1;
  assign HBLANK_O   = hblank_p1;
  assign VBLANK_O   = vblank_p1;
  assign LOCKED     = locked_p1;
  assign DE         = locked_p1 & ~hblank_p1 & ~vblank_p1;
  assign H_TOTAL    = htot_q;
  assign V_TOTAL    = vtot_q;
  assign FRAME_CNT  = fcnt_q;

endmodule

// File: tb/tb_video_frame_timer.sv
// -----------------------------------------------------------------------------
// tb_video_frame_timer
//
// Drives a scaled-down video raster (16 px lines, 8 or 9 line frames) so that
// many frames fit in a short run. The DUT limits are scaled to match:
// H 14..18, V 6..10, timeout at 11 lines, 12 active px with 2 px crop.
// Each driven pixel pushes its expected output set to a queue; the monitor
// pops one entry per CE_PIXEL_O strobe and checks that outputs hold between
// strobes.
// -----------------------------------------------------------------------------
module tb_video_frame_timer;

  localparam int LINE = 16;  // pixels per line
  localparam int HS_W = 2;   // HSYNC low pixels at line start
  localparam int HB_W = 4;   // HBLANK pixels at line start
  localparam int ACT  = 12;  // active pixels per line
  localparam int CROP = 2;
  localparam int VB_L = 2;   // VBLANK lines at frame start
  localparam logic [5:0] RST_V = 6'b111100; // {HS,VS,HB,VB,DE,LOCKED}

  logic       CLK_24MB  = 1'b0;
  logic       nRESETP   = 1'b1;
  logic       CE_PIX    = 1'b0;
  logic       HSYNC     = 1'b1;
  logic       VSYNC     = 1'b1;
  logic       HBLANK_IN = 1'b1;
  logic       VBLANK_IN = 1'b1;
  logic       CROP304   = 1'b0;
  logic       CE_PIXEL_O, HS_O, VS_O, HBLANK_O, VBLANK_O, DE, LOCKED;
  logic [9:0] H_TOTAL;
  logic [8:0] V_TOTAL;
  logic [7:0] FRAME_CNT;

  video_frame_timer #(
    .H_MIN(14), .H_MAX(18), .V_MIN(6), .V_MAX(10), .CROP_PIX(CROP), .ACT_PIX(ACT)
  ) dut (
    .CLK_24MB(CLK_24MB), .nRESETP(nRESETP), .CE_PIX(CE_PIX),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .HBLANK_IN(HBLANK_IN), .VBLANK_IN(VBLANK_IN),
    .CROP304(CROP304), .CE_PIXEL_O(CE_PIXEL_O), .HS_O(HS_O), .VS_O(VS_O),
    .HBLANK_O(HBLANK_O), .VBLANK_O(VBLANK_O), .DE(DE), .LOCKED(LOCKED),
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK_24MB = ~CLK_24MB;

  typedef struct {
    logic [5:0] v;
    int         tag;
  } exp_t;

  typedef struct {
    int nl;
    bit crop;
    bit lk;
    int vt;
    int fc;
    int de_px;
  } vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [5:0] last = RST_V;
  logic [5:0] outv;
  int         nchk = 0;
  int         nerr = 0;
  int         de_cnt = 0;
  int         cur_frame = 0;
  int         cur_line = 0;
  bit         mon_en = 1'b0;
  logic       crop_prev = 1'b0;
  vec_t       tbl[8];

  assign outv = {HS_O, VS_O, HBLANK_O, VBLANK_O, DE, LOCKED};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge CLK_24MB) begin
    if (mon_en) begin
      if (CE_PIXEL_O === 1'b1) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL ce_pixel_o strobe with nothing expected at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("pix f%0d l%0d", mon_e.tag / 100, mon_e.tag % 100),
              32'(outv), 32'(mon_e.v));
          if (DE === 1'b1) de_cnt++;
          last = mon_e.v;
        end
      end else begin
        chk("hold", 32'(outv), 32'(last));
      end
    end
  end

  // Called just after a rising edge; leaves CE_PIX high for exactly one clock.
  task automatic pix(input logic hs, input logic vs, input logic hb, input logic vb,
                     input logic crop, input logic [5:0] ev, input int gap);
    exp_t e;
    HSYNC     = hs;
    VSYNC     = vs;
    HBLANK_IN = hb;
    VBLANK_IN = vb;
    CROP304   = crop;
    CE_PIX    = 1'b1;
    e.v   = ev;
    e.tag = cur_frame * 100 + cur_line;
    @(posedge CLK_24MB);
    #1;
    CE_PIX = 1'b0;
    sb.push_back(e);
    repeat (gap - 1) begin
      @(posedge CLK_24MB);
      #1;
    end
  endtask

  task automatic send_line(input bit vs_low, input bit vb, input int len,
                           input bit crop, input bit lk, input int gap);
    for (int px = 0; px < len; px++) begin
      logic hs, hb, hbe;
      int   a;
      hs  = (px < HS_W) ? 1'b0 : 1'b1;
      hb  = (px < HB_W) ? 1'b1 : 1'b0;
      a   = px - HB_W;
      // crop follows the CROP304 value presented on the previous pixel
      hbe = hb | (crop_prev & ((a < CROP) || (a >= ACT - CROP)));
      crop_prev = crop;
      pix(hs, ~vs_low, hb, vb, crop, {hs, ~vs_low, hbe, vb, lk & ~hbe & ~vb, lk}, gap);
    end
  endtask

  // Lines before chg_ln expect LOCKED=lk_a, the rest lk_b.
  task automatic send_frame(input int nl, input bit crop, input bit vs_en,
                            input int short_ln, input bit lk_a, input bit lk_b,
                            input int chg_ln, input int gap);
    for (int ln = 0; ln < nl; ln++) begin
      cur_line = ln;
      send_line(vs_en && (ln == 0), ln < VB_L, (ln == short_ln) ? LINE - 1 : LINE,
                crop, (ln < chg_ln) ? lk_a : lk_b, gap);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //            nl crop lk vt fc de_px
    tbl[0] = '{9, 1'b0, 1'b0, 0, 0, 0};   // first vfall: SEARCH -> MEASURE
    tbl[1] = '{9, 1'b0, 1'b1, 9, 0, 84};  // second vfall locks on 9 lines
    tbl[2] = '{9, 1'b0, 1'b1, 9, 1, 84};
    tbl[3] = '{8, 1'b0, 1'b1, 9, 2, 72};  // switch to 8 lines, old frame still 9
    tbl[4] = '{8, 1'b0, 1'b0, 8, 3, 0};   // height changed -> MEASURE
    tbl[5] = '{8, 1'b0, 1'b1, 8, 3, 72};  // relocked on 8 lines
    tbl[6] = '{8, 1'b1, 1'b1, 8, 4, 48};  // crop: 8 of 12 px per line
    tbl[7] = '{8, 1'b0, 1'b1, 8, 5, 72};

    // power-on reset
    #1;
    nRESETP = 1'b0;
    mon_en  = 1'b1;
    #1;
    chk("reset_outs", 32'(outv), 32'(RST_V));
    chk("reset_ce", 32'(CE_PIXEL_O), 32'd0);
    chk("reset_totals", 32'({H_TOTAL, V_TOTAL, FRAME_CNT}), 32'd0);
    repeat (3) @(posedge CLK_24MB);
    #1;
    nRESETP = 1'b1;
    @(posedge CLK_24MB);
    #1;

    for (int i = 0; i < 8; i++) begin
      cur_frame = i;
      de_cnt = 0;
      send_frame(tbl[i].nl, tbl[i].crop, 1'b1, -1, tbl[i].lk, tbl[i].lk, 999, 4);
      chk($sformatf("h_total f%0d", i), 32'(H_TOTAL), 32'd16);
      chk($sformatf("v_total f%0d", i), 32'(V_TOTAL), 32'(tbl[i].vt));
      chk($sformatf("frame_cnt f%0d", i), 32'(FRAME_CNT), 32'(tbl[i].fc));
      chk($sformatf("locked f%0d", i), 32'(LOCKED), 32'(tbl[i].lk));
      chk($sformatf("de_px f%0d", i), 32'(de_cnt), 32'(tbl[i].de_px));
    end

    // 15 px line 4 while locked: unlock from line 5 px 0
    cur_frame = 8;
    send_frame(8, 1'b0, 1'b1, 4, 1'b1, 1'b0, 5, 4);
    chk("bad_line locked", 32'(LOCKED), 32'd0);
    chk("bad_line frame_cnt", 32'(FRAME_CNT), 32'd6);
    // frame carrying the bad line cannot lock; next clean frame relocks
    cur_frame = 9;
    send_frame(8, 1'b0, 1'b1, -1, 1'b0, 1'b0, 999, 4);
    chk("clean1 locked", 32'(LOCKED), 32'd0);
    cur_frame = 10;
    send_frame(8, 1'b0, 1'b1, -1, 1'b1, 1'b1, 999, 4);
    chk("relock locked", 32'(LOCKED), 32'd1);
    chk("relock frame_cnt", 32'(FRAME_CNT), 32'd6);
    chk("relock v_total", 32'(V_TOTAL), 32'd8);

    // VSYNC stays high: line 10 makes vcnt 11 and drops lock
    cur_frame = 11;
    send_frame(13, 1'b0, 1'b1, -1, 1'b1, 1'b0, 10, 4);
    chk("timeout locked", 32'(LOCKED), 32'd0);
    chk("timeout frame_cnt", 32'(FRAME_CNT), 32'd7);
    cur_frame = 12;
    send_frame(4, 1'b0, 1'b0, -1, 1'b0, 1'b0, 999, 4);
    chk("timeout fc frozen", 32'(FRAME_CNT), 32'd7);
    chk("timeout v_total", 32'(V_TOTAL), 32'd8);

    // reset in the middle of an active pixel run
    cur_frame = 13;
    cur_line = 0;
    send_line(1'b0, 1'b0, 6, 1'b0, 1'b0, 4);
    #2;
    nRESETP   = 1'b0;
    last      = RST_V;
    crop_prev = 1'b0;
    sb.delete();
    #1;
    chk("midline reset outs", 32'(outv), 32'(RST_V));
    chk("midline reset ce", 32'(CE_PIXEL_O), 32'd0);
    chk("midline reset totals", 32'({H_TOTAL, V_TOTAL, FRAME_CNT}), 32'd0);
    repeat (3) @(posedge CLK_24MB);
    #1;
    nRESETP = 1'b1;
    @(posedge CLK_24MB);
    #1;

    // back-to-back pixels; lock then run FRAME_CNT through its wrap
    cur_frame = 100;
    send_frame(8, 1'b0, 1'b1, -1, 1'b0, 1'b0, 999, 1);
    for (int k = 1; k <= 256; k++) begin
      cur_frame = 100 + k;
      send_frame(8, 1'b0, 1'b1, -1, 1'b1, 1'b1, 999, 1);
    end
    chk("wrap fc 255", 32'(FRAME_CNT), 32'd255);
    chk("wrap locked", 32'(LOCKED), 32'd1);
    cur_frame = 357;
    send_frame(8, 1'b0, 1'b1, -1, 1'b1, 1'b1, 999, 1);
    chk("wrap fc 0", 32'(FRAME_CNT), 32'd0);

    repeat (3) @(posedge CLK_24MB);
    #1;
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
